// File: rtl/bin2bcd_20b_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter.
package bin2bcd_20b_pkg;

    localparam int W_DEF      = 20;
    localparam int DIGITS_DEF = 7;
    localparam int DIGIT_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd_20b_if.sv
// Start/busy/done handshake and data bus between calculator control and converter.
interface bin2bcd_20b_if
    import bin2bcd_20b_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int DIGITS = DIGITS_DEF
);
    logic                        start;
    logic [W-1:0]                bin;
    logic                        busy;
    logic                        done;
    logic [DIGIT_W*DIGITS-1:0]   bcd;

    modport master (output start, output bin, input busy, input done, input bcd);
    modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/bin2bcd_20b_bcd_add3.sv
// Single BCD digit adjust for double dabble: add 3 when the digit is 5 or more.
module bcd_add3
    import bin2bcd_20b_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    // Pre-shift correction so the digit carries correctly after doubling
    always_comb begin
        dout = din;
        if (din >= DIGIT_W'(5)) begin
            dout = din + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_20b.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
module bin2bcd_20b
    import bin2bcd_20b_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int DIGITS = DIGITS_DEF
)(
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_20b_if.slave  bus
);

    localparam int BW = DIGIT_W * DIGITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t          state;
    logic [BW+W-1:0] work;
    logic [CW-1:0]   cnt;
    logic            busy_q;
    logic            done_q;
    logic [BW-1:0]   bcd_q;

    logic [BW-1:0]   digit_adj;
    logic [BW+W-1:0] shifted;

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (work[W + d*DIGIT_W +: DIGIT_W]),
            .dout (digit_adj[d*DIGIT_W +: DIGIT_W])
        );
    end

    // Adjusted digits plus untouched binary field, shifted left one place
    always_comb begin
        shifted = '0;
        shifted = {digit_adj[BW-2:0], work[W-1:0], 1'b0};
    end

    // Control FSM with working register, bit counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bcd_q  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        work[BW+W-1:W] <= '0;
                        work[W-1:0]    <= bus.bin;
                        cnt            <= '0;
                        busy_q         <= 1'b1;
                        state          <= SHIFT;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt + 1'b1;
                    // Old count W-1 means this edge performs the W-th shift
                    if (cnt == CW'(W - 1)) begin
                        bcd_q  <= shifted[BW+W-1:W];
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_20b.sv
// Directed-vector bench for the 20-bit binary-to-BCD converter.
module tb_bin2bcd_20b;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    bin2bcd_20b_if #(.W(20), .DIGITS(7)) bus ();

    bin2bcd_20b #(.W(20), .DIGITS(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;
        #3;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++;
        if (bus.bcd !== 28'h0) begin errors++; $display("FAIL reset_bcd: got %h expected 0000000", bus.bcd); end
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_conv(input logic [19:0] v, input logic [27:0] exp_bcd, input string name);
        int          lat;
        int          busy_cnt;
        int          hold_err;
        logic [27:0] prev;
        lat      = 0;
        busy_cnt = 0;
        hold_err = 0;
        prev     = bus.bcd;
        bus.start = 1'b1;
        bus.bin   = v;
        tick();
        bus.start = 1'b0;
        bus.bin   = ~v;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.bcd !== prev) hold_err++;
            tick();
            lat++;
        end
        checks++;
        if (lat !== 20) begin errors++; $display("FAIL %s_latency: got %0d expected 20", name, lat); end
        checks++;
        if (busy_cnt !== 20) begin errors++; $display("FAIL %s_busy_cycles: got %0d expected 20", name, busy_cnt); end
        checks++;
        if (hold_err !== 0) begin errors++; $display("FAIL %s_bcd_hold: got %0d changes expected 0", name, hold_err); end
        checks++;
        if (bus.bcd !== exp_bcd) begin errors++; $display("FAIL %s_bcd: got %h expected %h", name, bus.bcd, exp_bcd); end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b expected 0", name, bus.done); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_idle_busy: got %b expected 0", name, bus.busy); end
    endtask

    task automatic test_values();
        run_conv(20'd0,       28'h0000000, "zero");
        run_conv(20'd1048575, 28'h1048575, "max");
        run_conv(20'd12345,   28'h0012345, "v12345");
        run_conv(20'd99999,   28'h0099999, "v99999");
    endtask

    task automatic test_ignore_start();
        int lat;
        int done_cnt;
        int done_at;
        done_cnt  = 0;
        done_at   = -1;
        bus.start = 1'b1;
        bus.bin   = 20'd777;
        tick();
        bus.start = 1'b0;
        for (lat = 0; lat < 30; lat++) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_at = lat;
                checks++;
                if (bus.bcd !== 28'h0000777) begin errors++; $display("FAIL ignore_bcd: got %h expected 0000777", bus.bcd); end
            end
            bus.start = (lat == 3 || lat == 10) ? 1'b1 : 1'b0;
            bus.bin   = 20'd5;
            tick();
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); end
        checks++;
        if (done_at !== 20) begin errors++; $display("FAIL ignore_done_time: got %0d expected 20", done_at); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_idle: got %b expected 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          n;
        int          t0;
        int          t1;
        logic [27:0] r0;
        logic [27:0] r1;
        n  = 0;
        t0 = -1;
        t1 = -1;
        r0 = '0;
        r1 = '0;
        bus.start = 1'b1;
        bus.bin   = 20'd42;
        tick();
        lat = 0;
        while (n < 2 && lat < 80) begin
            if (bus.done === 1'b1) begin
                if (n == 0) begin
                    t0 = lat; r0 = bus.bcd; bus.bin = 20'd43;
                end else begin
                    t1 = lat; r1 = bus.bcd; bus.start = 1'b0;
                end
                n++;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        checks++;
        if (n !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", n); end
        checks++;
        if (t1 - t0 !== 21) begin errors++; $display("FAIL b2b_spacing: got %0d expected 21", t1 - t0); end
        checks++;
        if (r0 !== 28'h0000042) begin errors++; $display("FAIL b2b_first: got %h expected 0000042", r0); end
        checks++;
        if (r1 !== 28'h0000043) begin errors++; $display("FAIL b2b_second: got %h expected 0000043", r1); end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_async_reset();
        int done_cnt;
        done_cnt  = 0;
        bus.start = 1'b1;
        bus.bin   = 20'd654321;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b expected 0", bus.done); end
        checks++;
        if (bus.bcd !== 28'h0) begin errors++; $display("FAIL arst_bcd: got %h expected 0000000", bus.bcd); end
        tick();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL arst_no_done: got %0d expected 0", done_cnt); end
        run_conv(20'd31415, 28'h0031415, "post_reset");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_values();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
